// File: rtl/de_port_arbiter.sv
// Round-robin arbiter sharing the drawing-engine memory port between two masters.
// Optional burst locking is compiled in with the DE_ARB_LOCK_EN macro.
module de_port_arbiter #(
   parameter int ADDR_W  = 18,
   parameter int DATA_W  = 32,
   parameter int NBYTE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               m0_req,
   output logic               m0_ack,
   input  logic [ADDR_W-1:0]  m0_addr,
   input  logic [NBYTE_W-1:0] m0_nbyte,
   input  logic               m0_rnw,
   input  logic [DATA_W-1:0]  m0_w_data,
   output logic [DATA_W-1:0]  m0_r_data,
`ifdef DE_ARB_LOCK_EN
   input  logic               m0_lock,
   input  logic               m1_lock,
`endif
   input  logic               m1_req,
   output logic               m1_ack,
   input  logic [ADDR_W-1:0]  m1_addr,
   input  logic [NBYTE_W-1:0] m1_nbyte,
   input  logic               m1_rnw,
   input  logic [DATA_W-1:0]  m1_w_data,
   output logic [DATA_W-1:0]  m1_r_data,
   output logic               de_req,
   input  logic               de_ack,
   output logic [ADDR_W-1:0]  de_addr,
   output logic [NBYTE_W-1:0] de_nbyte,
   output logic               de_rnw,
   output logic [DATA_W-1:0]  de_w_data,
   input  logic [DATA_W-1:0]  de_r_data,
   output logic               grant_id
);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   state_t state_reg, state_next;
   logic   last_reg, last_next;
   logic   grant_id_reg, grant_id_next;
   logic   lock0, lock1;

`ifdef DE_ARB_LOCK_EN
   assign lock0 = m0_lock;
   assign lock1 = m1_lock;
`else
   assign lock0 = 1'b0;
   assign lock1 = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         last_reg     <= 1'b1;
         grant_id_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_reg     <= last_next;
         grant_id_reg <= grant_id_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (m0_req && m1_req)
               state_next = last_reg ? GNT0 : GNT1;
            else if (m0_req)
               state_next = GNT0;
            else if (m1_req)
               state_next = GNT1;
         end
         GNT0: begin
            // A dropped request abandons the access; a late ack is then ignored in IDLE.
            if (!m0_req)
               state_next = IDLE;
            else if (de_ack) begin
               last_next = 1'b0;
               if (lock0)
                  state_next = GNT0;
               else if (m1_req)
                  state_next = GNT1;
               else
                  state_next = IDLE;
            end
         end
         GNT1: begin
            if (!m1_req)
               state_next = IDLE;
            else if (de_ack) begin
               last_next = 1'b1;
               if (lock1)
                  state_next = GNT1;
               else if (m0_req)
                  state_next = GNT0;
               else
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      grant_id_next = grant_id_reg;
      if (state_next == GNT0)
         grant_id_next = 1'b0;
      else if (state_next == GNT1)
         grant_id_next = 1'b1;
   end

   always_comb begin
      de_req    = 1'b0;
      de_addr   = '0;
      de_nbyte  = '0;
      de_rnw    = 1'b0;
      de_w_data = '0;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      m0_r_data = '0;
      m1_r_data = '0;
      case (state_reg)
         GNT0: begin
            de_req    = m0_req;
            de_addr   = m0_addr;
            de_nbyte  = m0_nbyte;
            de_rnw    = m0_rnw;
            de_w_data = m0_w_data;
            m0_ack    = de_ack;
            m0_r_data = de_r_data;
         end
         GNT1: begin
            de_req    = m1_req;
            de_addr   = m1_addr;
            de_nbyte  = m1_nbyte;
            de_rnw    = m1_rnw;
            de_w_data = m1_w_data;
            m1_ack    = de_ack;
            m1_r_data = de_r_data;
         end
         default: ;
      endcase
   end

   assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_de_port_arbiter.sv
// Directed bench for de_port_arbiter; inputs driven and outputs sampled on the falling edge.
// Define DE_ARB_LOCK_EN for both files to exercise burst locking.
module tb_de_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m1_req, m0_ack, m1_ack;
   logic [17:0] m0_addr, m1_addr;
   logic [3:0]  m0_nbyte, m1_nbyte;
   logic        m0_rnw, m1_rnw;
   logic [31:0] m0_w_data, m1_w_data, m0_r_data, m1_r_data;
   logic        de_req, de_ack, de_rnw, grant_id;
   logic [17:0] de_addr;
   logic [3:0]  de_nbyte;
   logic [31:0] de_w_data, de_r_data;
`ifdef DE_ARB_LOCK_EN
   logic        m0_lock, m1_lock;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   de_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_ack(m0_ack), .m0_addr(m0_addr), .m0_nbyte(m0_nbyte),
      .m0_rnw(m0_rnw), .m0_w_data(m0_w_data), .m0_r_data(m0_r_data),
`ifdef DE_ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .m1_req(m1_req), .m1_ack(m1_ack), .m1_addr(m1_addr), .m1_nbyte(m1_nbyte),
      .m1_rnw(m1_rnw), .m1_w_data(m1_w_data), .m1_r_data(m1_r_data),
      .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
      .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
      .grant_id(grant_id)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else
         $display("ok   %s: %h", tag, obs);
   endtask

   initial begin
      rst_n = 1'b0;
      m0_req = 1'b1; m0_addr = 18'h0ABCD; m0_nbyte = 4'h0; m0_rnw = 1'b0; m0_w_data = 32'h11112222;
      m1_req = 1'b0; m1_addr = 18'h0; m1_nbyte = 4'h0; m1_rnw = 1'b0; m1_w_data = 32'h0;
      de_ack = 1'b0; de_r_data = 32'h0;
`ifdef DE_ARB_LOCK_EN
      m0_lock = 1'b0; m1_lock = 1'b0;
`endif

      // reset with m0 already requesting
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_de_req", 32'(de_req), 32'h0);
      check_eq("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
      check_eq("rst_grant_id", 32'(grant_id), 32'h0);
      check_eq("rst_de_addr", 32'(de_addr), 32'h0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check_eq("rel_de_req", 32'(de_req), 32'h1);
      check_eq("rel_de_addr", 32'(de_addr), 32'h0ABCD);
      check_eq("rel_w_data", de_w_data, 32'h11112222);
      de_ack = 1'b1; #1;
      check_eq("rel_m0_ack", {30'h0, m1_ack, m0_ack}, 32'h1);
      @(negedge clk);
      de_ack = 1'b0; m0_req = 1'b0; #1;
      check_eq("rel_idle_de_req", 32'(de_req), 32'h0);

      // single read by m1 with 3-cycle memory latency
      m1_req = 1'b1; m1_addr = 18'h00123; m1_rnw = 1'b1; m1_nbyte = 4'h5;
      @(negedge clk); #1;
      check_eq("rd_de_req", 32'(de_req), 32'h1);
      check_eq("rd_de_addr", 32'(de_addr), 32'h00123);
      check_eq("rd_de_rnw", 32'(de_rnw), 32'h1);
      check_eq("rd_de_nbyte", 32'(de_nbyte), 32'h5);
      check_eq("rd_grant_id", 32'(grant_id), 32'h1);
      repeat (2) @(negedge clk);
      de_ack = 1'b1; de_r_data = 32'hDEADBEEF; #1;
      check_eq("rd_m1_ack", 32'(m1_ack), 32'h1);
      check_eq("rd_m1_r_data", m1_r_data, 32'hDEADBEEF);
      check_eq("rd_m0_ack", 32'(m0_ack), 32'h0);
      check_eq("rd_m0_r_data", m0_r_data, 32'h0);
      @(negedge clk);
      de_ack = 1'b0; m1_req = 1'b0; #1;
      check_eq("rd_ack_pulse", 32'(m1_ack), 32'h0);

      // contention: m1 served last, so m0 wins; then m1 with no idle gap
      m0_req = 1'b1; m0_addr = 18'h01000; m0_rnw = 1'b0;
      m1_req = 1'b1; m1_addr = 18'h02000;
      @(negedge clk); #1;
      check_eq("ct_grant0", 32'(grant_id), 32'h0);
      check_eq("ct_addr0", 32'(de_addr), 32'h01000);
      de_ack = 1'b1; #1;
      check_eq("ct_m0_ack", {30'h0, m1_ack, m0_ack}, 32'h1);
      @(negedge clk);
      de_ack = 1'b0; m0_req = 1'b0; #1;
      check_eq("ct_nobubble_req", 32'(de_req), 32'h1);
      check_eq("ct_grant1", 32'(grant_id), 32'h1);
      check_eq("ct_addr1", 32'(de_addr), 32'h02000);
      de_ack = 1'b1; #1;
      check_eq("ct_m1_ack", {30'h0, m1_ack, m0_ack}, 32'h2);
      @(negedge clk);
      de_ack = 1'b0; m1_req = 1'b0;

      // fairness: both held for six transactions
      m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         de_ack = 1'b0;
         if (i == 5) m0_req = 1'b0;
         #1;
         check_eq($sformatf("fair_grant_%0d", i), 32'(grant_id), 32'(i % 2));
         check_eq($sformatf("fair_req_%0d", i), 32'(de_req), 32'h1);
         @(negedge clk);
         de_ack = 1'b1; #1;
         check_eq($sformatf("fair_ack_%0d", i), {30'h0, m1_ack, m0_ack}, (i % 2 == 0) ? 32'h1 : 32'h2);
      end
      @(negedge clk);
      de_ack = 1'b0; m1_req = 1'b0; #1;
      check_eq("fair_end_req", 32'(de_req), 32'h0);

      // abort: m0 drops before ack, then a stray ack in IDLE
      m0_req = 1'b1; m0_addr = 18'h03333;
      @(negedge clk); #1;
      check_eq("ab_granted", 32'(de_req), 32'h1);
      m0_req = 1'b0; #1;
      check_eq("ab_drop_same_cycle", 32'(de_req), 32'h0);
      @(negedge clk);
      de_ack = 1'b1; #1;
      check_eq("ab_stray_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
      check_eq("ab_idle_addr", 32'(de_addr), 32'h0);
      @(negedge clk);
      de_ack = 1'b0;

`ifdef DE_ARB_LOCK_EN
      // lock: three locked m0 accesses ahead of a waiting m1
      m0_req = 1'b1; m1_req = 1'b1; m0_lock = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         de_ack = 1'b0;
         if (i == 2) m0_lock = 1'b0;
         #1;
         check_eq($sformatf("lk_grant_%0d", i), 32'(grant_id), 32'h0);
         de_ack = 1'b1; #1;
         check_eq($sformatf("lk_ack_%0d", i), {30'h0, m1_ack, m0_ack}, 32'h1);
      end
      @(negedge clk);
      de_ack = 1'b0; m0_req = 1'b0; #1;
      check_eq("lk_then_m1", 32'(grant_id), 32'h1);
      check_eq("lk_then_m1_req", 32'(de_req), 32'h1);
      de_ack = 1'b1; #1;
      @(negedge clk);
      de_ack = 1'b0; m1_req = 1'b0;
`endif

      // reset mid-transaction
      m1_req = 1'b1; m1_addr = 18'h04444;
      @(negedge clk); #1;
      check_eq("mr_granted", 32'(grant_id), 32'h1);
      rst_n = 1'b0; #1;
      check_eq("mr_de_req", 32'(de_req), 32'h0);
      check_eq("mr_grant_id", 32'(grant_id), 32'h0);
      check_eq("mr_de_addr", 32'(de_addr), 32'h0);
      m1_req = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
